skid_pipe_reg: RTL and testbench

- Consumer-side counterpart to the enable-driven pipeline register.
  - There, the producer decides when data moves.
  - Here, the downstream stage back-pressures the upstream stage through a valid/ready handshake.
- Two-entry skid buffer inserted between pipeline stages (e.g. IF/ID, ID/EX) so stalls propagate without a combinational ready path.
- Sustains one transfer per cycle.
- Supports a synchronous flush for branch mispredicts.

---
 rtl/skid_pipe_reg_pkg.sv | 34 +++
 rtl/skid_pipe_reg.sv | 103 ++++++++++
 tb/tb_skid_pipe_reg.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/skid_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : skid_pipe_reg_pkg
//  Brief    : State encoding and flag helpers shared by the skid pipeline reg.
//  Revision : 1.0  initial release
// ============================================================================
package skid_pipe_reg_pkg;

    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_EMPTY = 2'b00;
    localparam logic [c_STATE_W-1:0] c_HALF  = 2'b01;
    localparam logic [c_STATE_W-1:0] c_FULL  = 2'b10;

    // The unused encoding folds onto EMPTY so a corrupted state self-recovers.
    function automatic logic [c_STATE_W-1:0] f_decode(input logic [c_STATE_W-1:0] state);
        logic [c_STATE_W-1:0] dec;
        dec = c_EMPTY;
        if (state == c_HALF || state == c_FULL) begin
            dec = state;
        end
        return dec;
    endfunction

    function automatic logic f_has_data(input logic [c_STATE_W-1:0] state);
        return (state != c_EMPTY);
    endfunction

    function automatic logic f_has_room(input logic [c_STATE_W-1:0] state);
        return (state != c_FULL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/skid_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : skid_pipe_reg
//  Brief    : Two-entry valid/ready skid buffer with registered ready and
//             synchronous flush, for back-pressured pipeline boundaries.
//  Revision : 1.0  initial release
// ============================================================================
module skid_pipe_reg
    import skid_pipe_reg_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         iFLUSH,
    input  logic         iVALID,
    output logic         oREADY,
    input  logic [N-1:0] iD,
    output logic         oVALID,
    input  logic         iREADY,
    output logic [N-1:0] oD
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_dec;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [N-1:0]         r_m;
    logic [N-1:0]         r_s;
    logic [N-1:0]         w_m_nxt;
    logic [N-1:0]         w_s_nxt;
    logic                 r_valid;
    logic                 r_ready;
    logic                 w_in_xfer;
    logic                 w_out_xfer;

    // Handshakes only look at registered flags, so iREADY never reaches oREADY.
    assign w_in_xfer  = iVALID & r_ready;
    assign w_out_xfer = r_valid & iREADY;

    always_comb begin
        w_state_dec = f_decode(r_state);
        w_state_nxt = w_state_dec;
        w_m_nxt     = r_m;
        w_s_nxt     = r_s;
        case (w_state_dec)
            c_EMPTY: begin
                if (w_in_xfer) begin
                    w_m_nxt     = iD;
                    w_state_nxt = c_HALF;
                end
            end
            c_HALF: begin
                case ({w_in_xfer, w_out_xfer})
                    2'b11: begin
                        w_m_nxt = iD;
                    end
                    2'b10: begin
                        // Downstream stalled: park the new word behind M.
                        w_s_nxt     = iD;
                        w_state_nxt = c_FULL;
                    end
                    2'b01: begin
                        w_state_nxt = c_EMPTY;
                    end
                    default: begin
                        w_state_nxt = c_HALF;
                    end
                endcase
            end
            c_FULL: begin
                if (w_out_xfer) begin
                    w_m_nxt     = r_s;
                    w_state_nxt = c_HALF;
                end
            end
            default: begin
                w_state_nxt = c_EMPTY;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST || iFLUSH) begin
            r_state <= c_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_m     <= '0;
            r_s     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= f_has_data(w_state_nxt);
            r_ready <= f_has_room(w_state_nxt);
            r_m     <= w_m_nxt;
            r_s     <= w_s_nxt;
        end
    end

    assign oVALID = r_valid;
    assign oREADY = r_ready;
    assign oD     = r_m;

endmodule
`default_nettype wire

// File: tb/tb_skid_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_skid_pipe_reg
//  Brief    : Self-checking bench: queue model plus directed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_skid_pipe_reg;

    localparam int c_N = 64;

    logic           r_clk;
    logic           r_rst;
    logic           r_flush;
    logic           r_vin;
    logic [c_N-1:0] r_d;
    logic           r_rdy_in;
    logic           w_ready;
    logic           w_valid;
    logic [c_N-1:0] w_d;

    int n_cmp = 0;
    int n_err = 0;

    skid_pipe_reg #(.N(c_N)) u_dut (
        .iCLK   (r_clk),
        .iRST   (r_rst),
        .iFLUSH (r_flush),
        .iVALID (r_vin),
        .oREADY (w_ready),
        .iD     (r_d),
        .oVALID (w_valid),
        .iREADY (r_rdy_in),
        .oD     (w_d)
    );

    initial begin
        r_clk = 1'b1;
        forever #5 r_clk = ~r_clk;
    end

    task automatic chk(input string name, input logic [c_N-1:0] act, input logic [c_N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, let the edge consume them, return just after it.
    task automatic cyc(input logic rst, input logic flush, input logic v,
                       input logic [c_N-1:0] d, input logic rdy);
        r_rst    = rst;
        r_flush  = flush;
        r_vin    = v;
        r_d      = d;
        r_rdy_in = rdy;
        @(posedge r_clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic rdy, input logic [c_N-1:0] d);
        chk({name, "_valid"}, {63'd0, w_valid}, {63'd0, v});
        chk({name, "_ready"}, {63'd0, w_ready}, {63'd0, rdy});
        chk({name, "_data"},  w_d, d);
    endtask

    // Model: the buffer is a FIFO of at most two words; oD shows the head,
    // or the last word popped once the FIFO has drained.
    initial begin
        logic [c_N-1:0] q[$];
        logic [c_N-1:0] last;
        logic           exp_v;
        logic           exp_r;
        logic [c_N-1:0] exp_d;
        bit             started;
        bit             in_x;
        bit             out_x;
        last    = '0;
        started = 0;
        forever begin
            @(negedge r_clk);
            if (started) begin
                exp_v = (q.size() > 0);
                exp_r = (q.size() < 2);
                exp_d = exp_v ? q[0] : last;
                chk("mdl_valid", {63'd0, w_valid}, {63'd0, exp_v});
                chk("mdl_ready", {63'd0, w_ready}, {63'd0, exp_r});
                chk("mdl_data",  w_d, exp_d);
            end
            started = 1;
            if (r_rst || r_flush) begin
                q.delete();
                last = '0;
            end else begin
                in_x  = r_vin && (q.size() < 2);
                out_x = (q.size() > 0) && r_rdy_in;
                if (out_x) last = q.pop_front();
                if (in_x) q.push_back(r_d);
            end
        end
    end

    initial begin
        logic           hold;
        logic           v;
        logic           fl;
        logic           rdy_before;
        logic [c_N-1:0] d;

        // Reset with an offered word that must not be taken.
        cyc(1, 0, 1, 64'hDEAD, 1);
        cyc(1, 0, 1, 64'hDEAD, 1);
        chk_out("reset", 0, 1, 64'd0);

        // Streaming, one word per cycle, one cycle latency.
        cyc(0, 0, 1, 64'd1, 1);
        chk_out("stream1", 1, 1, 64'd1);
        cyc(0, 0, 1, 64'd2, 1);
        chk_out("stream2", 1, 1, 64'd2);
        cyc(0, 0, 1, 64'd3, 1);
        chk_out("stream3", 1, 1, 64'd3);
        cyc(0, 0, 1, 64'd4, 1);
        chk_out("stream4", 1, 1, 64'd4);
        cyc(0, 0, 0, 64'd0, 1);
        chk("stream_drain_valid", {63'd0, w_valid}, 64'd0);

        // Stall and skid: 11 lands in S, 12 waits upstream.
        cyc(0, 0, 1, 64'd10, 1);
        chk_out("skid_10", 1, 1, 64'd10);
        cyc(0, 0, 1, 64'd11, 0);
        chk_out("skid_full", 1, 0, 64'd10);
        cyc(0, 0, 1, 64'd12, 0);
        chk_out("skid_hold", 1, 0, 64'd10);
        cyc(0, 0, 1, 64'd12, 1);
        chk_out("skid_11", 1, 1, 64'd11);
        cyc(0, 0, 1, 64'd12, 1);
        chk_out("skid_12", 1, 1, 64'd12);
        cyc(0, 0, 0, 64'd0, 1);
        chk_out("skid_empty", 0, 1, 64'd12);

        // Hold stability while FULL and stalled.
        cyc(0, 0, 1, 64'd30, 0);
        cyc(0, 0, 1, 64'd31, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, {$urandom, $urandom}, 0);
            chk_out("hold", 1, 0, 64'd30);
        end
        cyc(0, 0, 0, 64'd0, 1);
        chk_out("hold_drain31", 1, 1, 64'd31);
        cyc(0, 0, 0, 64'd0, 1);

        // Flush in FULL discards 20, 21 and the offered 22.
        cyc(0, 0, 1, 64'd20, 0);
        cyc(0, 0, 1, 64'd21, 0);
        chk_out("pre_flush", 1, 0, 64'd20);
        cyc(0, 1, 1, 64'd22, 1);
        chk_out("flush", 0, 1, 64'd0);
        cyc(0, 0, 0, 64'd0, 1);
        chk_out("post_flush", 0, 1, 64'd0);

        // Reset and flush together with handshakes active.
        cyc(0, 0, 1, 64'd40, 1);
        cyc(1, 1, 1, 64'd41, 1);
        chk_out("rst_flush", 0, 1, 64'd0);

        // HALF with simultaneous in and out transfers.
        cyc(0, 0, 1, 64'd50, 1);
        cyc(0, 0, 1, 64'd51, 1);
        chk_out("half_inout", 1, 1, 64'd51);

        // Random traffic; the upstream holds a word until it is accepted.
        hold = 0;
        d    = '0;
        for (int i = 0; i < 300; i++) begin
            rdy_before = w_ready;
            v  = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!hold) d = {$urandom, $urandom};
            fl = ($urandom_range(0, 40) == 0);
            cyc(0, fl, v, d, ($urandom_range(0, 2) != 0));
            hold = v && !rdy_before && !fl;
        end

        cyc(0, 0, 0, 64'd0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
